fetch_sequencer: RTL and testbench

Sequences the combinational instruction memory for the Y86-64 core. Drives the fetch PC and samples the 10-byte window plus imem_error. Splits and validates the instruction, computes valP, and hands one decoded instruction at a time to the downstream stage over a valid/ready handshake. Accepts PC redirects from execute (jXX/call/ret) and enters a terminal state on halt, address error or invalid instruction.

---
 rtl/fetch_sequencer.sv | 136 +++++++++++++
 tb/tb_fetch_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: Y86-64 fetch sequencer over a combinational 10-byte imem window; define FETCH_PERF_EN to add perf_issued/perf_stall counters
module fetch_sequencer #(
  parameter int MEM_SIZE = 1024,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [63:0]          start_pc,
  output logic [63:0]          imem_pc,
  input  logic [7:0]           imem_byte0,
  input  logic [7:0]           imem_byte1,
  input  logic [7:0]           imem_byte2,
  input  logic [7:0]           imem_byte3,
  input  logic [7:0]           imem_byte4,
  input  logic [7:0]           imem_byte5,
  input  logic [7:0]           imem_byte6,
  input  logic [7:0]           imem_byte7,
  input  logic [7:0]           imem_byte8,
  input  logic [7:0]           imem_byte9,
  input  logic                 imem_error,
  input  logic                 redirect_valid,
  input  logic [63:0]          redirect_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           out_icode,
  output logic [3:0]           out_ifun,
  output logic [3:0]           out_rA,
  output logic [3:0]           out_rB,
  output logic [63:0]          out_valC,
  output logic [63:0]          out_valP,
  output logic [63:0]          out_pc,
  output logic [1:0]           out_stat,
  output logic                 busy
`ifdef FETCH_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0] perf_issued,
  output logic [CNT_WIDTH-1:0] perf_stall
`endif
);
  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALTED} state_t;
  state_t state, state_next;
  logic [63:0] pc_reg, pc_next;
  logic [3:0] icode, ifun, len;
  logic has_regs, fn_ok, adr, ins, bad;
  logic [64:0] end_addr;
  logic [63:0] valc_raw;
  logic [1:0] stat;
  logic start_ok, fetch_ok;
  assign imem_pc = pc_reg;
  assign out_valid = state == ISSUE;
  assign busy = state == FETCH || state == ISSUE;
  assign start_ok = (state == IDLE || state == HALTED) && start;
  assign fetch_ok = state == FETCH && !redirect_valid;
  assign icode = imem_byte0[7:4];
  assign ifun = imem_byte0[3:0];
  assign len = icode inside {4'h3, 4'h4, 4'h5} ? 4'd10 :
               icode inside {4'h7, 4'h8} ? 4'd9 :
               icode inside {4'h2, 4'h6, 4'hA, 4'hB} ? 4'd2 : 4'd1;
  assign has_regs = icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
  assign valc_raw = icode inside {4'h7, 4'h8} ?
                      {imem_byte8, imem_byte7, imem_byte6, imem_byte5, imem_byte4, imem_byte3, imem_byte2, imem_byte1} :
                    icode inside {4'h3, 4'h4, 4'h5} ?
                      {imem_byte9, imem_byte8, imem_byte7, imem_byte6, imem_byte5, imem_byte4, imem_byte3, imem_byte2} :
                    64'd0;
  assign fn_ok = icode inside {4'h2, 4'h7} ? ifun <= 4'd6 : icode == 4'h6 ? ifun <= 4'd3 : ifun == 4'd0;
  // 65-bit sum so a PC near the top of the address space cannot wrap past the bound check
  assign end_addr = {1'b0, pc_reg} + 65'(len);
  assign adr = imem_error || end_addr > 65'(MEM_SIZE);
  assign ins = icode >= 4'hC || !fn_ok;
  assign bad = adr || ins;
  assign stat = adr ? 2'd2 : ins ? 2'd3 : icode == 4'h0 ? 2'd1 : 2'd0;
  always_comb begin
    state_next = state;
    pc_next = pc_reg;
    case (state)
      IDLE, HALTED: begin
        state_next = start ? FETCH : state;
        pc_next = start ? start_pc : pc_reg;
      end
      FETCH: begin
        state_next = redirect_valid ? FETCH : ISSUE;
        pc_next = redirect_valid ? redirect_pc : pc_reg;
      end
      ISSUE: begin
        state_next = out_ready ? (out_stat == 2'd0 ? FETCH : HALTED) : redirect_valid ? FETCH : ISSUE;
        pc_next = out_ready ? (out_stat == 2'd0 ? (redirect_valid ? redirect_pc : out_valP) : pc_reg) :
                  redirect_valid ? redirect_pc : pc_reg;
      end
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg <= '0;
      out_icode <= '0;
      out_ifun <= '0;
      out_rA <= '0;
      out_rB <= '0;
      out_valC <= '0;
      out_valP <= '0;
      out_pc <= '0;
      out_stat <= '0;
    end else begin
      pc_reg <= pc_next;
      if (fetch_ok) begin
        out_icode <= icode;
        out_ifun <= ifun;
        out_rA <= has_regs ? imem_byte1[7:4] : 4'hF;
        out_rB <= has_regs ? imem_byte1[3:0] : 4'hF;
        out_valC <= bad ? 64'd0 : valc_raw;
        out_valP <= bad ? pc_reg : pc_reg + 64'(len);
        out_pc <= pc_reg;
        out_stat <= stat;
      end
    end
  end
`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      perf_issued <= '0;
      perf_stall <= '0;
    end else if (state == ISSUE) begin
      if (out_ready && perf_issued != '1) perf_issued <= perf_issued + CNT_WIDTH'(1);
      if (!out_ready && perf_stall != '1) perf_stall <= perf_stall + CNT_WIDTH'(1);
    end
  end
`else
  logic unused;
  assign unused = start_ok;
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;
  logic clk = 0;
  logic rst = 0, start = 0, redirect_valid = 0, out_ready = 0;
  logic [63:0] start_pc = 0, redirect_pc = 0, imem_pc;
  logic imem_error, out_valid, busy;
  logic [3:0] out_icode, out_ifun, out_rA, out_rB;
  logic [63:0] out_valC, out_valP, out_pc;
  logic [1:0] out_stat;
  logic [7:0] mem [1024];
  logic [7:0] win [10];
  logic [210:0] bun;
  int total = 0, bad = 0;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_issued, perf_stall;
`endif
  always #5 clk = ~clk;
  genvar k;
  for (k = 0; k < 10; k++) begin : g_win
    assign win[k] = (imem_pc + 64'(k)) < 64'd1024 ? mem[10'(imem_pc + 64'(k))] : 8'h00;
  end
  assign imem_error = imem_pc >= 64'd1024;
  assign bun = {out_valid, out_icode, out_ifun, out_rA, out_rB, out_valC, out_valP, out_pc, out_stat};
  fetch_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .start_pc(start_pc), .imem_pc(imem_pc),
    .imem_byte0(win[0]), .imem_byte1(win[1]), .imem_byte2(win[2]), .imem_byte3(win[3]),
    .imem_byte4(win[4]), .imem_byte5(win[5]), .imem_byte6(win[6]), .imem_byte7(win[7]),
    .imem_byte8(win[8]), .imem_byte9(win[9]), .imem_error(imem_error),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_icode(out_icode), .out_ifun(out_ifun), .out_rA(out_rA), .out_rB(out_rB),
    .out_valC(out_valC), .out_valP(out_valP), .out_pc(out_pc), .out_stat(out_stat),
    .busy(busy)
`ifdef FETCH_PERF_EN
    , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic load_prog1();
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[0] = 8'h30; mem[1] = 8'hF2; mem[2] = 8'h0A;
    mem[10] = 8'h10; mem[11] = 8'h00;
  endtask
  task automatic do_reset();
    rst = 1; start = 0; redirect_valid = 0; out_ready = 0;
    step();
    rst = 0;
  endtask
  task automatic do_start(input logic [63:0] pc);
    start = 1; start_pc = pc;
    step();
    start = 0;
  endtask
  task automatic test_reset();
    load_prog1();
    do_reset();
    total++; if (bun !== 211'd0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", bun); end
    total++; if (imem_pc !== 64'd0) begin bad++; $display("FAIL reset_imem_pc got=%h exp=0", imem_pc); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    out_ready = 1;
    step();
    total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL idle_no_start got busy=%b valid=%b exp 0 0", busy, out_valid); end
  endtask
  task automatic test_program();
    out_ready = 1;
    do_start(64'd0);
    total++; if (busy !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL p1_fetch got busy=%b valid=%b exp 1 0", busy, out_valid); end
    step();
    total++; if (bun !== {1'b1, 4'h3, 4'h0, 4'hF, 4'h2, 64'd10, 64'd10, 64'd0, 2'd0}) begin bad++; $display("FAIL p1_irmovq got=%h", bun); end
    step();
    total++; if (out_valid !== 1'b0 || imem_pc !== 64'd10) begin bad++; $display("FAIL p1_fetch2 got valid=%b pc=%h exp 0 a", out_valid, imem_pc); end
    step();
    total++; if (bun !== {1'b1, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd11, 64'd10, 2'd0}) begin bad++; $display("FAIL p1_nop got=%h", bun); end
    step(); step();
    total++; if (bun !== {1'b1, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd12, 64'd11, 2'd1}) begin bad++; $display("FAIL p1_halt got=%h", bun); end
    step();
    total++; if (bun !== {1'b0, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd12, 64'd11, 2'd1}) begin bad++; $display("FAIL p1_halted_hold got=%h", bun); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL p1_halted_busy got=%b exp=0", busy); end
    step();
    total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL p1_halted_stay got busy=%b valid=%b", busy, out_valid); end
  endtask
  task automatic test_stall();
    out_ready = 0;
    do_start(64'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      total++; if (bun !== {1'b1, 4'h3, 4'h0, 4'hF, 4'h2, 64'd10, 64'd10, 64'd0, 2'd0}) begin bad++; $display("FAIL stall_hold%0d got=%h", i, bun); end
      step();
    end
    total++; if (bun !== {1'b1, 4'h3, 4'h0, 4'hF, 4'h2, 64'd10, 64'd10, 64'd0, 2'd0}) begin bad++; $display("FAIL stall_hold3 got=%h", bun); end
    out_ready = 1;
    step();
    total++; if (out_valid !== 1'b0 || imem_pc !== 64'd10) begin bad++; $display("FAIL stall_once got valid=%b pc=%h exp 0 a", out_valid, imem_pc); end
    step();
    total++; if (out_pc !== 64'd10 || out_icode !== 4'h1) begin bad++; $display("FAIL stall_next got pc=%h icode=%h exp a 1", out_pc, out_icode); end
    step(); step(); step();
    total++; if (busy !== 1'b0 || out_stat !== 2'd1) begin bad++; $display("FAIL stall_halted got busy=%b stat=%0d exp 0 1", busy, out_stat); end
`ifdef FETCH_PERF_EN
    total++; if (perf_issued !== 32'd3) begin bad++; $display("FAIL perf_issued got=%0d exp=3", perf_issued); end
    total++; if (perf_stall !== 32'd3) begin bad++; $display("FAIL perf_stall got=%0d exp=3", perf_stall); end
`endif
  endtask
  task automatic test_reset_mid_issue();
    out_ready = 0;
    do_start(64'd0);
    step();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rmid_pre got valid=%b exp=1", out_valid); end
    rst = 1;
    step();
    rst = 0;
    total++; if (bun !== 211'd0 || imem_pc !== 64'd0 || busy !== 1'b0) begin bad++; $display("FAIL rmid_reset got=%h pc=%h busy=%b", bun, imem_pc, busy); end
    out_ready = 1;
    step(); step();
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rmid_needs_start got valid=%b busy=%b", out_valid, busy); end
    do_start(64'd0);
    step();
    total++; if (bun !== {1'b1, 4'h3, 4'h0, 4'hF, 4'h2, 64'd10, 64'd10, 64'd0, 2'd0}) begin bad++; $display("FAIL rmid_resume got=%h", bun); end
  endtask
  task automatic test_redirect();
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[0] = 8'h70; mem[1] = 8'h20; mem[32] = 8'h10; mem[64] = 8'h00;
    do_reset();
    out_ready = 1;
    do_start(64'd0);
    step();
    total++; if (bun !== {1'b1, 4'h7, 4'h0, 4'hF, 4'hF, 64'h20, 64'd9, 64'd0, 2'd0}) begin bad++; $display("FAIL jxx_decode got=%h", bun); end
    redirect_valid = 1; redirect_pc = 64'h20;
    step();
    redirect_valid = 0;
    total++; if (imem_pc !== 64'h20) begin bad++; $display("FAIL jxx_redirect_pc got=%h exp=20", imem_pc); end
    step();
    total++; if (bun !== {1'b1, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'h21, 64'h20, 2'd0}) begin bad++; $display("FAIL jxx_target got=%h", bun); end
    out_ready = 0; redirect_valid = 1; redirect_pc = 64'h40;
    step();
    redirect_valid = 0; out_ready = 1;
    total++; if (out_valid !== 1'b0 || imem_pc !== 64'h40) begin bad++; $display("FAIL squash got valid=%b pc=%h exp 0 40", out_valid, imem_pc); end
    step();
    total++; if (bun !== {1'b1, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h41, 64'h40, 2'd1}) begin bad++; $display("FAIL squash_next got=%h", bun); end
  endtask
  task automatic test_errors();
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[0] = 8'h65; mem[1] = 8'h12; mem[256] = 8'h65; mem[257] = 8'h12;
    mem[1020] = 8'h30; mem[1021] = 8'hF2; mem[1022] = 8'h0A;
    do_reset();
    out_ready = 1;
    do_start(64'd0);
    step();
    total++; if (bun !== {1'b1, 4'h6, 4'h5, 4'h1, 4'h2, 64'd0, 64'd0, 64'd0, 2'd3}) begin bad++; $display("FAIL ins_decode got=%h", bun); end
    step();
    total++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_stat !== 2'd3) begin bad++; $display("FAIL ins_halted got valid=%b busy=%b stat=%0d", out_valid, busy, out_stat); end
    do_start(64'h100);
    step();
    total++; if (bun !== {1'b1, 4'h6, 4'h5, 4'h1, 4'h2, 64'd0, 64'h100, 64'h100, 2'd3}) begin bad++; $display("FAIL ins_restart got=%h", bun); end
    step();
    do_start(64'd1020);
    step();
    total++; if (bun !== {1'b1, 4'h3, 4'h0, 4'hF, 4'h2, 64'd0, 64'd1020, 64'd1020, 2'd2}) begin bad++; $display("FAIL adr_len got=%h", bun); end
    step();
    mem[1023] = 8'h10;
    do_start(64'd1023);
    step();
    total++; if (bun !== {1'b1, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1024, 64'd1023, 2'd0}) begin bad++; $display("FAIL adr_edge_ok got=%h", bun); end
    step(); step();
    total++; if (bun !== {1'b1, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1024, 64'd1024, 2'd2}) begin bad++; $display("FAIL adr_imem_error got=%h", bun); end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset();
    test_program();
    test_stall();
    test_reset_mid_issue();
    test_redirect();
    test_errors();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
